hex_step_counter: RTL

- Upstream stage of the per-digit hex-to-7-segment decoders on the DE1-SoC board.
- Turns raw active-low pushbuttons into a debounced, auto-repeating up/down hex counter.
- Presents DIGITS nibbles, one per downstream decoder, plus leading-zero blank flags.
- Also supports a parallel load of a switch-supplied value.

---
 rtl/hex_step_counter_pkg.sv | 9 +
 rtl/key_debounce.sv | 32 +++
 rtl/hex_step_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/hex_step_counter_pkg.sv
// hex_step_counter_pkg: shared FSM states, direction codes and simulation-size timing
package hex_step_counter_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, WAIT_REL} state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY = 20;
  localparam int SIM_REPEAT_RATE = 5;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter and one-cycle press pulse for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt <= '0;
        press <= level;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/hex_step_counter.sv
// hex_step_counter: debounced auto-repeating up/down hex counter with parallel load and leading-zero blanking
module hex_step_counter
  import hex_step_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE = 5000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_inc_n,
  input  logic                  key_dec_n,
  input  logic                  key_load_n,
  input  logic [DIGITS*4-1:0]   load_val,
  output logic [DIGITS*4-1:0]   value,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  step
);
  localparam int W = DIGITS * 4;
  localparam int TW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [2:0] keys, lvl, prs;
  state_t state, state_nx;
  logic dir, dir_nx, step_nx, held, load_p;
  logic [TW-1:0] timer, timer_nx;
  logic [W-1:0] val_nx;
  assign keys = {key_load_n, key_dec_n, key_inc_n};
  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .key_n(keys[k]), .level(lvl[k]), .press(prs[k])
    );
  end
  assign load_p = prs[2] & ~lvl[2];
  assign held = (dir == DIR_DN) ? ~lvl[1] : ~lvl[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= DIR_UP;
      timer <= '0;
      value <= '0;
      step <= 1'b0;
    end else begin
      state <= state_nx;
      dir <= dir_nx;
      timer <= timer_nx;
      value <= val_nx;
      step <= step_nx;
    end
  always_comb begin
    state_nx = state;
    dir_nx = dir;
    timer_nx = timer;
    val_nx = value;
    step_nx = 1'b0;
    if (load_p) begin
      val_nx = load_val;
      timer_nx = '0;
      state_nx = (!lvl[0] || !lvl[1]) ? WAIT_REL : IDLE;
    end else
      case (state)
        IDLE:
          if (prs[0] || prs[1]) begin
            if (!lvl[0] && !lvl[1]) state_nx = WAIT_REL;
            else begin
              dir_nx = prs[0] ? DIR_UP : DIR_DN;
              step_nx = 1'b1;
              timer_nx = '0;
              state_nx = DELAY;
            end
          end
        DELAY, REPEAT:
          if (!held) state_nx = IDLE;
          else if (timer == (state == DELAY ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_RATE - 1))) begin
            step_nx = 1'b1;
            timer_nx = '0;
            state_nx = REPEAT;
          end else timer_nx = timer + 1'b1;
        WAIT_REL: if (lvl[0] && lvl[1]) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    if (step_nx) val_nx = (dir_nx == DIR_UP) ? value + 1'b1 : value - 1'b1;
  end
  // digit i blanks when everything from nibble i upward is zero
  always_comb begin
    digit_blank = '0;
    for (int i = 1; i < DIGITS; i++) digit_blank[i] = (value >> (4 * i)) == '0;
  end
endmodule
